// File: rtl/sdm_array.sv
// Multi-channel sigma-delta modulator: NUM_CH signed fixed-point streams to +/-1 bitstreams,
// first- or second-order loop with guard-bit error state, saturation clamp and sticky flags.
module sdm_array #(
    parameter int BIT_WIDTH  = 16,
    parameter int INT_WIDTH  = 1,
    parameter int NUM_CH     = 4,
    parameter int ORDER      = 1,
    parameter int GUARD_BITS = 3
) (
    input  logic                        CLK,
    input  logic                        nRST,
    input  logic                        en,
    input  logic                        x_valid,
    input  logic [NUM_CH*BIT_WIDTH-1:0] x,
    output logic                        x_ready,
    output logic [NUM_CH-1:0]           y,
    output logic                        y_valid,
    output logic [NUM_CH-1:0]           sat,
    input  logic                        clr_sat
);

    localparam int FRAC  = BIT_WIDTH - INT_WIDTH - 1;
    localparam int ACC_W = BIT_WIDTH + GUARD_BITS;
    // Three extra bits cover x + 2*e1 - e2 - q without overflow before the clamp.
    localparam int CW    = ACC_W + 3;

    localparam logic signed [CW-1:0] Q_POS = CW'(64'sd1 <<< FRAC);
    localparam logic signed [CW-1:0] E_MAX = CW'((64'sd1 <<< (ACC_W - 1)) - 64'sd1);
    localparam logic signed [CW-1:0] E_MIN = CW'(-(64'sd1 <<< (ACC_W - 1)));

    if ((ORDER != 32'sd1) && (ORDER != 32'sd2)) begin : g_bad_order
        $error("sdm_array: ORDER must be 1 or 2");
    end
    if (NUM_CH < 32'sd1) begin : g_bad_ch
        $error("sdm_array: NUM_CH must be at least 1");
    end

    // Returns {clamp_active, clamped_error}; the wide error never wraps into ACC_W.
    function automatic logic [ACC_W:0] clamp_err(input logic signed [CW-1:0] e);
        logic [ACC_W:0] r;
        if (e > E_MAX) begin
            r = {1'b1, E_MAX[ACC_W-1:0]};
        end else if (e < E_MIN) begin
            r = {1'b1, E_MIN[ACC_W-1:0]};
        end else begin
            r = {1'b0, e[ACC_W-1:0]};
        end
        return r;
    endfunction

    logic step_s;
    logic y_valid_r;

    assign step_s  = en & x_valid;
    assign x_ready = en;
    assign y_valid = y_valid_r;

    // Output-valid flag: high for exactly the cycles following an accepted sample.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            y_valid_r <= 1'b0;
        end else begin
            y_valid_r <= step_s;
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        logic signed [ACC_W-1:0] e1_r;
        logic signed [CW-1:0]    xs_s;
        logic signed [CW-1:0]    e1x_s;
        logic signed [CW-1:0]    v_s;
        logic signed [CW-1:0]    e_raw_s;
        logic signed [ACC_W-1:0] e_clamped_s;
        logic                    clamp_s;
        logic                    ybit_s;
        logic                    y_r;
        logic                    sat_r;

        assign xs_s  = {{(CW-BIT_WIDTH){x[k*BIT_WIDTH+BIT_WIDTH-1]}}, x[k*BIT_WIDTH +: BIT_WIDTH]};
        assign e1x_s = {{3{e1_r[ACC_W-1]}}, e1_r};

        if (ORDER == 32'sd2) begin : g_o2
            logic signed [ACC_W-1:0] e2_r;
            logic signed [CW-1:0]    e2x_s;

            assign e2x_s = {{3{e2_r[ACC_W-1]}}, e2_r};
            // NTF (1 - z^-1)^2: feed back twice the last error minus the one before it.
            assign v_s   = xs_s + e1x_s + e1x_s - e2x_s;

            // Second error tap: delayed copy of e1, advanced only on accepted samples.
            always_ff @(posedge CLK) begin
                if (!nRST) begin
                    e2_r <= '0;
                end else if (step_s) begin
                    e2_r <= e1_r;
                end else begin
                    e2_r <= e2_r;
                end
            end
        end else begin : g_o1
            assign v_s = xs_s + e1x_s;
        end

        assign ybit_s  = ~v_s[CW-1];
        assign e_raw_s = ybit_s ? (v_s - Q_POS) : (v_s + Q_POS);
        assign {clamp_s, e_clamped_s} = clamp_err(e_raw_s);

        // Loop state and output bit advance together on each accepted sample.
        always_ff @(posedge CLK) begin
            if (!nRST) begin
                e1_r <= '0;
                y_r  <= 1'b0;
            end else if (step_s) begin
                e1_r <= e_clamped_s;
                y_r  <= ybit_s;
            end else begin
                e1_r <= e1_r;
                y_r  <= y_r;
            end
        end

        // Sticky saturation flag; a fresh clamp outranks a simultaneous clear.
        always_ff @(posedge CLK) begin
            if (!nRST) begin
                sat_r <= 1'b0;
            end else if (step_s && clamp_s) begin
                sat_r <= 1'b1;
            end else if (clr_sat) begin
                sat_r <= 1'b0;
            end else begin
                sat_r <= sat_r;
            end
        end

        assign y[k]   = y_r;
        assign sat[k] = sat_r;
    end

endmodule

// File: tb/tb_sdm_array.sv
// Self-checking bench for sdm_array: three configurations (order 1, order 2, order 2 without
// guard bits) share stimulus and are compared against an integer-arithmetic reference model.
module tb_sdm_array;

    localparam int     BW  = 16;
    localparam int     NCH = 4;
    localparam longint Q   = 64'sd16384;

    logic            CLK = 1'b0;
    logic            nRST = 1'b0;
    logic            en = 1'b0;
    logic            x_valid = 1'b0;
    logic            clr_sat = 1'b0;
    logic [NCH*BW-1:0] x = '0;

    logic [NCH-1:0] y_o   [3];
    logic [NCH-1:0] sat_o [3];
    logic           yv_o  [3];
    logic           xr_o  [3];

    int errors = 0;
    int checks = 0;

    int     ord  [3] = '{1, 2, 2};
    int     accw [3] = '{19, 19, 16};
    longint me1  [3][NCH];
    longint me2  [3][NCH];
    logic [NCH-1:0] my   [3];
    logic [NCH-1:0] msat [3];
    logic           mvalid [3];

    always #5 CLK = ~CLK;

    sdm_array #(.BIT_WIDTH(16), .INT_WIDTH(1), .NUM_CH(4), .ORDER(1), .GUARD_BITS(3)) d1 (
        .CLK(CLK), .nRST(nRST), .en(en), .x_valid(x_valid), .x(x), .x_ready(xr_o[0]),
        .y(y_o[0]), .y_valid(yv_o[0]), .sat(sat_o[0]), .clr_sat(clr_sat));
    sdm_array #(.BIT_WIDTH(16), .INT_WIDTH(1), .NUM_CH(4), .ORDER(2), .GUARD_BITS(3)) d2 (
        .CLK(CLK), .nRST(nRST), .en(en), .x_valid(x_valid), .x(x), .x_ready(xr_o[1]),
        .y(y_o[1]), .y_valid(yv_o[1]), .sat(sat_o[1]), .clr_sat(clr_sat));
    sdm_array #(.BIT_WIDTH(16), .INT_WIDTH(1), .NUM_CH(4), .ORDER(2), .GUARD_BITS(0)) d3 (
        .CLK(CLK), .nRST(nRST), .en(en), .x_valid(x_valid), .x(x), .x_ready(xr_o[2]),
        .y(y_o[2]), .y_valid(yv_o[2]), .sat(sat_o[2]), .clr_sat(clr_sat));

    // One modulator step in plain integers: quantise, subtract q, clamp to the error range.
    function automatic void calc(input int o, input int aw, input longint xs, input longint e1,
                                 input longint e2, output bit yb, output longint enew, output bit cl);
        longint v, e, hi, lo;
        v    = (o == 1) ? xs + e1 : xs + 2 * e1 - e2;
        yb   = (v >= 0);
        e    = yb ? v - Q : v + Q;
        hi   = (64'sd1 <<< (aw - 1)) - 1;
        lo   = -(64'sd1 <<< (aw - 1));
        cl   = (e > hi) || (e < lo);
        enew = (e > hi) ? hi : ((e < lo) ? lo : e);
    endfunction

    function automatic longint samp(input int k);
        logic signed [BW-1:0] s;
        s = x[k*BW +: BW];
        return longint'(s);
    endfunction

    task automatic model_edge();
        bit     step, yb, cl;
        longint enew;
        step = en & x_valid;
        for (int d = 0; d < 3; d++) begin
            mvalid[d] = nRST ? step : 1'b0;
            for (int k = 0; k < NCH; k++) begin
                if (!nRST) begin
                    me1[d][k] = 0; me2[d][k] = 0; my[d][k] = 1'b0; msat[d][k] = 1'b0;
                end else begin
                    cl = 1'b0;
                    if (step) begin
                        calc(ord[d], accw[d], samp(k), me1[d][k], me2[d][k], yb, enew, cl);
                        me2[d][k] = (ord[d] == 2) ? me1[d][k] : 0;
                        me1[d][k] = enew;
                        my[d][k]  = yb;
                    end
                    if (step && cl) msat[d][k] = 1'b1;
                    else if (clr_sat) msat[d][k] = 1'b0;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        nRST = 1'b0; en = 1'b1; x_valid = 1'b1; x = {$urandom, $urandom};
        for (int i = 0; i < 3; i++) begin
            tick();
            for (int d = 0; d < 3; d++) begin
                checks++;
                if (y_o[d] !== 4'h0 || yv_o[d] !== 1'b0 || sat_o[d] !== 4'h0) begin
                    errors++;
                    $display("FAIL reset d%0d cyc%0d y=%b yv=%b sat=%b want 0", d, i, y_o[d], yv_o[d], sat_o[d]);
                end
            end
        end
        nRST = 1'b1;
    endtask

    task automatic test_order1_zero();
        logic [3:0] exp_y;
        x = '0; en = 1'b1; x_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            exp_y = (i % 2 == 0) ? 4'hF : 4'h0;
            checks++;
            if (y_o[0] !== exp_y || yv_o[0] !== 1'b1) begin
                errors++;
                $display("FAIL o1_zero cyc%0d y=%b yv=%b want y=%b yv=1", i, y_o[0], yv_o[0], exp_y);
            end
            for (int d = 0; d < 3; d++) begin
                checks++;
                if (y_o[d] !== my[d] || yv_o[d] !== mvalid[d] || sat_o[d] !== msat[d]) begin
                    errors++;
                    $display("FAIL o1_zero_model d%0d y=%b/%b yv=%b/%b sat=%b/%b", d, y_o[d], my[d],
                             yv_o[d], mvalid[d], sat_o[d], msat[d]);
                end
            end
        end
    endtask

    task automatic test_order1_half();
        logic [3:0] exp_y;
        nRST = 1'b0; tick(); nRST = 1'b1;
        x = {4{16'h2000}};
        for (int i = 0; i < 1000; i++) begin
            tick();
            exp_y = (i % 4 == 2) ? 4'h0 : 4'hF;
            checks++;
            if (y_o[0] !== exp_y) begin
                errors++;
                $display("FAIL o1_half cyc%0d y=%b want %b", i, y_o[0], exp_y);
            end
            for (int d = 0; d < 3; d++) begin
                checks++;
                if (y_o[d] !== my[d] || yv_o[d] !== mvalid[d] || sat_o[d] !== msat[d]) begin
                    errors++;
                    $display("FAIL o1_half_model d%0d cyc%0d y=%b/%b yv=%b/%b sat=%b/%b", d, i, y_o[d],
                             my[d], yv_o[d], mvalid[d], sat_o[d], msat[d]);
                end
            end
        end
    endtask

    task automatic test_order2();
        logic [3:0] exp_y;
        int ones;
        nRST = 1'b0; tick(); nRST = 1'b1;
        x = '0;
        for (int i = 0; i < 8; i++) begin
            tick();
            exp_y = (i % 4 == 0 || i % 4 == 3) ? 4'hF : 4'h0;
            checks++;
            if (y_o[1] !== exp_y || y_o[2] !== exp_y) begin
                errors++;
                $display("FAIL o2_zero cyc%0d y=%b,%b want %b", i, y_o[1], y_o[2], exp_y);
            end
        end
        x = {4{16'h3000}};
        ones = 0;
        for (int i = 0; i < 4096; i++) begin
            tick();
            ones += int'(y_o[1][0]);
            for (int d = 0; d < 3; d++) begin
                checks++;
                if (y_o[d] !== my[d] || yv_o[d] !== mvalid[d] || sat_o[d] !== msat[d]) begin
                    errors++;
                    $display("FAIL o2_075_model d%0d cyc%0d y=%b/%b yv=%b/%b sat=%b/%b", d, i, y_o[d],
                             my[d], yv_o[d], mvalid[d], sat_o[d], msat[d]);
                end
            end
        end
        checks++;
        if (ones < 3564 || ones > 3604) begin
            errors++;
            $display("FAIL o2_density ones=%0d want 3564..3604 of 4096", ones);
        end
        checks++;
        if (sat_o[1] !== 4'h0) begin
            errors++;
            $display("FAIL o2_sat sat=%b want 0000", sat_o[1]);
        end
    endtask

    task automatic test_gating();
        bit         gold [$];
        longint     e, v;
        int         idx;
        logic [3:0] prev_y;
        nRST = 1'b0; tick(); nRST = 1'b1;
        x = {16'hE000, 16'($urandom), 16'($urandom), 16'h1000};
        e = 0;
        for (int i = 0; i < 400; i++) begin
            v = 4096 + e;
            gold.push_back(v >= 0);
            e = (v >= 0) ? v - Q : v + Q;
        end
        idx = 0;
        for (int i = 0; i < 400; i++) begin
            en = 1'($urandom); x_valid = 1'($urandom);
            #1;
            checks++;
            if (xr_o[0] !== en || xr_o[2] !== en) begin
                errors++;
                $display("FAIL x_ready cyc%0d got=%b,%b want %b", i, xr_o[0], xr_o[2], en);
            end
            prev_y = y_o[0];
            tick();
            checks++;
            if (yv_o[0]) begin
                if (y_o[0][0] !== gold[idx]) begin
                    errors++;
                    $display("FAIL gate_gold acc%0d y0=%b want %b", idx, y_o[0][0], gold[idx]);
                end
                idx++;
            end else if (y_o[0] !== prev_y) begin
                errors++;
                $display("FAIL gate_hold cyc%0d y=%b want %b", i, y_o[0], prev_y);
            end
            for (int d = 0; d < 3; d++) begin
                checks++;
                if (y_o[d] !== my[d] || yv_o[d] !== mvalid[d] || sat_o[d] !== msat[d]) begin
                    errors++;
                    $display("FAIL gate_model d%0d cyc%0d y=%b/%b yv=%b/%b sat=%b/%b", d, i, y_o[d],
                             my[d], yv_o[d], mvalid[d], sat_o[d], msat[d]);
                end
            end
        end
    endtask

    task automatic test_clamp();
        bit     found, yb, cl;
        longint enew;
        nRST = 1'b0; tick(); nRST = 1'b1;
        en = 1'b1; x_valid = 1'b1;
        x = {4{16'h7FFF}};
        for (int i = 0; i < 512; i++) begin
            tick();
            for (int d = 0; d < 3; d++) begin
                checks++;
                if (y_o[d] !== my[d] || yv_o[d] !== mvalid[d] || sat_o[d] !== msat[d]) begin
                    errors++;
                    $display("FAIL clamp_model d%0d cyc%0d y=%b/%b yv=%b/%b sat=%b/%b", d, i, y_o[d],
                             my[d], yv_o[d], mvalid[d], sat_o[d], msat[d]);
                end
            end
        end
        checks++;
        if (sat_o[2] !== 4'hF) begin
            errors++;
            $display("FAIL clamp_flag sat=%b want 1111", sat_o[2]);
        end
        x[BW +: BW] = 16'h0000;
        found = 1'b0;
        for (int i = 0; i < 64 && !found; i++) begin
            calc(2, 16, samp(0), me1[2][0], me2[2][0], yb, enew, cl);
            if (cl) found = 1'b1;
            else tick();
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL clamp_search no clamp edge within 64 cycles");
        end
        clr_sat = 1'b1;
        tick();
        clr_sat = 1'b0;
        checks++;
        if (sat_o[2][0] !== 1'b1 || sat_o[2] !== msat[2]) begin
            errors++;
            $display("FAIL clr_vs_clamp sat=%b want %b (bit0=1)", sat_o[2], msat[2]);
        end
        nRST = 1'b0; tick();
        checks++;
        if (y_o[2] !== 4'h0 || yv_o[2] !== 1'b0 || sat_o[2] !== 4'h0) begin
            errors++;
            $display("FAIL midrun_reset y=%b yv=%b sat=%b want 0", y_o[2], yv_o[2], sat_o[2]);
        end
        nRST = 1'b1; x = {4{16'h7FFF}};
        tick();
        checks++;
        if (y_o[2] !== 4'hF || yv_o[2] !== 1'b1 || y_o[2] !== my[2] || sat_o[2] !== msat[2]) begin
            errors++;
            $display("FAIL post_reset y=%b yv=%b sat=%b want y=1111 yv=1 sat=%b", y_o[2], yv_o[2],
                     sat_o[2], msat[2]);
        end
    endtask

    initial begin
        test_reset();
        test_order1_zero();
        test_order1_half();
        test_order2();
        test_gating();
        test_clamp();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
